// File: rtl/imm_ext_if.sv
// imm_ext_if: request/result bus between the per-slot decoders and the
// shared immediate extender. The slave modport is the extender's view.
interface imm_ext_if #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
);
    logic [NUM_SLOTS-1:0]    req_valid;
    logic [NUM_SLOTS-1:0]    req_ready;
    logic [11*NUM_SLOTS-1:0] req_imm;
    logic [2*NUM_SLOTS-1:0]  req_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic [SLOT_W-1:0]       out_slot;

    modport master (
        output req_valid, req_imm, req_mode, out_ready,
        input  req_ready, out_valid, out_data, out_slot
    );

    modport slave (
        input  req_valid, req_imm, req_mode, out_ready,
        output req_ready, out_valid, out_data, out_slot
    );
endinterface

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin arbitration of NUM_SLOTS immediate-extension
// requests onto one extender with a single registered output stage.
// Optional feature macro: IMM_EXT_MODE_CHECK_EN -- mode 2'b11 yields zero data
// and raises the sticky err_mode flag; when undefined, mode 2'b11 acts as zext8
// and the err_mode port does not exist.
module imm_ext_arbiter #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic     clk,
    input  logic     reset,
    imm_ext_if.slave bus
`ifdef IMM_EXT_MODE_CHECK_EN
    ,
    output logic     err_mode
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [31:0]         data_q, data_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SLOT_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic                found_s;
    logic [SLOT_W-1:0]   win_s;
    logic [SLOT_W:0]     scan_s;
    logic                can_accept_s;
    logic                xfer_s;
    logic [NUM_SLOTS-1:0] ready_s;
    logic [10:0]         win_imm_s;
    logic [1:0]          win_mode_s;

    // Extend an 11-bit immediate field according to its 2-bit mode.
    function automatic logic [31:0] extend_imm(input logic [10:0] imm, input logic [1:0] mode);
        logic [31:0] res;
        case (mode)
            2'b00:   res = {{24{imm[7]}}, imm[7:0]};
            2'b01:   res = {{21{imm[10]}}, imm[10:0]};
            2'b10:   res = {24'h000000, imm[7:0]};
`ifdef IMM_EXT_MODE_CHECK_EN
            2'b11:   res = 32'h00000000;
`else
            2'b11:   res = {24'h000000, imm[7:0]};
`endif
            default: res = 32'h00000000;
        endcase
        return res;
    endfunction

    // Round-robin scan: first valid slot at or after rr_ptr, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        scan_s  = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            scan_s = {1'b0, rr_ptr_q} + (SLOT_W+1)'(k);
            if (scan_s >= (SLOT_W+1)'(NUM_SLOTS)) begin
                scan_s = scan_s - (SLOT_W+1)'(NUM_SLOTS);
            end else begin
                scan_s = scan_s;
            end
            if (!found_s && bus.req_valid[scan_s[SLOT_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = scan_s[SLOT_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant: only the winner sees ready, and only when the output slot frees up.
    always_comb begin
        ready_s      = '0;
        can_accept_s = (state_q == EMPTY) || bus.out_ready;
        xfer_s       = found_s && can_accept_s && !reset;
        if (xfer_s) begin
            ready_s[win_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
        win_imm_s  = bus.req_imm[11*int'(win_s) +: 11];
        win_mode_s = bus.req_mode[2*int'(win_s) +: 2];
    end

    assign bus.req_ready = ready_s;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_slot  = slot_q;

`ifdef IMM_EXT_MODE_CHECK_EN
    logic err_q, err_d;
    assign err_mode = err_q;

    // Sticky flag: any accepted reserved-mode request latches it until reset.
    always_comb begin
        if (xfer_s && (win_mode_s == 2'b11)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Output-stage FSM next state plus result/pointer updates.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        slot_d   = slot_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            EMPTY: begin
                if (xfer_s) begin
                    state_d = FULL;
                end else begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (xfer_s) begin
                    state_d = FULL;
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end else begin
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (xfer_s) begin
            data_d = extend_imm(win_imm_s, win_mode_s);
            slot_d = win_s;
            if (win_s == SLOT_W'(NUM_SLOTS-1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_s + SLOT_W'(1);
            end
        end else begin
            data_d   = data_q;
            slot_d   = slot_q;
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State, output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            data_q   <= 32'h00000000;
            slot_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            slot_q   <= slot_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed bench for imm_ext_arbiter with a behavioural
// reference model and a per-cycle compare process.
module tb_imm_ext_arbiter;
    localparam int N = 4;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    imm_ext_if #(.NUM_SLOTS(N)) bus ();

`ifdef IMM_EXT_MODE_CHECK_EN
    logic err_mode;
    imm_ext_arbiter #(.NUM_SLOTS(N)) dut (.clk(clk), .reset(reset), .bus(bus), .err_mode(err_mode));
`else
    imm_ext_arbiter #(.NUM_SLOTS(N)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = 32'h0;
    int          m_slot  = 0;
    int          m_rr    = 0;
    logic        m_err   = 1'b0;

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_ext(input int s);
        int imm;
        int mode;
        int v;
        imm  = int'(bus.req_imm[11*s +: 11]);
        mode = int'(bus.req_mode[2*s +: 2]);
        case (mode)
            0: begin v = imm % 256;  if (v >= 128)  v = v - 256;  end
            1: begin v = imm % 2048; if (v >= 1024) v = v - 2048; end
            2: v = imm % 256;
`ifdef IMM_EXT_MODE_CHECK_EN
            3: v = 0;
`else
            3: v = imm % 256;
`endif
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [N-1:0] m_ready();
        int w;
        if (reset) return '0;
        w = m_winner();
        if (w >= 0 && (!m_valid || bus.out_ready)) return N'(1) << w;
        return '0;
    endfunction

    // Model state advances on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0; m_data <= 32'h0; m_slot <= 0; m_rr <= 0; m_err <= 1'b0;
        end else if (m_winner() >= 0 && (!m_valid || bus.out_ready)) begin
            m_valid <= 1'b1;
            m_data  <= m_ext(m_winner());
            m_slot  <= m_winner();
            m_rr    <= (m_winner() + 1) % N;
            if (bus.req_mode[2*m_winner() +: 2] == 2'b11) m_err <= 1'b1;
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("req_ready", 32'(bus.req_ready), 32'(m_ready()));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data",  bus.out_data, m_data);
        chk("out_slot",  32'(bus.out_slot), 32'(m_slot));
`ifdef IMM_EXT_MODE_CHECK_EN
        chk("err_mode",  32'(err_mode), 32'(m_err));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int s, input logic [10:0] imm, input logic [1:0] mode);
        bus.req_imm[11*s +: 11] = imm;
        bus.req_mode[2*s +: 2]  = mode;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_imm   = '0;
        bus.req_mode  = '0;
        bus.out_ready = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("lit_reset_valid", 32'(bus.out_valid), 32'h0);
        chk("lit_reset_data", bus.out_data, 32'h0);

        // Single sext8 request from slot 0.
        set_req(0, 11'h080, 2'b00);
        bus.req_valid = 4'b0001;
        tick(1);
        bus.req_valid = 4'b0000;
        chk("lit_t1_valid", 32'(bus.out_valid), 32'h1);
        chk("lit_t1_data", bus.out_data, 32'hFFFFFF80);
        chk("lit_t1_slot", 32'(bus.out_slot), 32'h0);

        // Fresh pointer, then slots 1 and 2 together.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        set_req(1, 11'h400, 2'b01);
        set_req(2, 11'h7FF, 2'b10);
        bus.req_valid = 4'b0110;
        tick(1);
        bus.req_valid = 4'b0100;
        chk("lit_t2a_data", bus.out_data, 32'hFFFFFC00);
        chk("lit_t2a_slot", 32'(bus.out_slot), 32'h1);
        tick(1);
        bus.req_valid = 4'b0000;
        chk("lit_t2b_data", bus.out_data, 32'h000000FF);
        chk("lit_t2b_slot", 32'(bus.out_slot), 32'h2);

        // Pointer must now sit at 3: all slots request, slot 3 wins first.
        set_req(0, 11'h7F0, 2'b00);
        set_req(1, 11'h3FF, 2'b01);
        set_req(2, 11'h6AB, 2'b10);
        set_req(3, 11'h155, 2'b00);
        bus.req_valid = 4'b1111;
        tick(1);
        chk("lit_rr3_slot", 32'(bus.out_slot), 32'h3);
        chk("lit_rr3_data", bus.out_data, 32'h00000055);

        // Reset while a result is pending; requests stay up through reset.
        reset = 1'b1;
        #1;
        chk("lit_rst_ready", 32'(bus.req_ready), 32'h0);
        tick(1);
        chk("lit_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("lit_rst_data", bus.out_data, 32'h0);
        reset = 1'b0;

        // All four slots continuously: grant order 0,1,2,3,0.
        tick(1);
        chk("lit_rr_g0", 32'(bus.out_slot), 32'h0);
        chk("lit_rr_d0", bus.out_data, 32'hFFFFFFF0);
        tick(1);
        chk("lit_rr_g1", 32'(bus.out_slot), 32'h1);
        chk("lit_rr_d1", bus.out_data, 32'h000003FF);
        tick(1);
        chk("lit_rr_g2", 32'(bus.out_slot), 32'h2);
        chk("lit_rr_d2", bus.out_data, 32'h000000AB);
        tick(1);
        chk("lit_rr_g3", 32'(bus.out_slot), 32'h3);
        tick(1);
        chk("lit_rr_g4", 32'(bus.out_slot), 32'h0);

        // Backpressure with slot 3 waiting.
        bus.req_valid = 4'b1000;
        bus.out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("lit_bp_ready", 32'(bus.req_ready), 32'h0);
            chk("lit_bp_data", bus.out_data, 32'hFFFFFFF0);
            tick(1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("lit_bp_release", 32'(bus.req_ready), 32'h8);
        tick(1);
        bus.req_valid = 4'b0000;
        chk("lit_bp_slot", 32'(bus.out_slot), 32'h3);
        chk("lit_bp_data3", bus.out_data, 32'h00000055);

        // Reserved mode.
        set_req(0, 11'h0A5, 2'b11);
        bus.req_valid = 4'b0001;
        tick(1);
        bus.req_valid = 4'b0000;
`ifdef IMM_EXT_MODE_CHECK_EN
        chk("lit_m11_data", bus.out_data, 32'h00000000);
        chk("lit_m11_err", 32'(err_mode), 32'h1);
        tick(3);
        chk("lit_m11_sticky", 32'(err_mode), 32'h1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("lit_m11_cleared", 32'(err_mode), 32'h0);
`else
        chk("lit_m11_data", bus.out_data, 32'h000000A5);
        tick(2);
        chk("lit_drain_valid", 32'(bus.out_valid), 32'h0);
        chk("lit_drain_hold", bus.out_data, 32'h000000A5);
`endif
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Shared immediate-extension unit for the VLIW decode stage. Up to NUM_SLOTS issue slots request extension of an 8-bit or 11-bit immediate field; the block arbitrates them round-robin onto one extender, registers the 32-bit result, and returns it with the winning slot index over a valid/ready handshake. It sits between the per-slot instruction decoders and the operand-select mux feeding the ALUs.

## Interface
- NUM_SLOTS, 4, number of requesting issue slots (2..8)
- SLOT_W, $clog2(NUM_SLOTS), width of slot index
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_SLOTS  per-slot request valid
- req_ready  out  NUM_SLOTS  per-slot accept; one-hot or zero
- req_imm  in  11*NUM_SLOTS  per-slot immediate, slot i at [11*i+10:11*i]
- req_mode  in  2*NUM_SLOTS  per-slot mode: 00 sext8, 01 sext11, 10 zext8, 11 reserved
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  32  extended immediate
- out_slot  out  SLOT_W  slot index of out_data
- err_mode  out  1  sticky reserved-mode flag (IMM_EXT_MODE_CHECK_EN only)

## Operation
- Extension: sext8 = {24{imm[7]}, imm[7:0]}; sext11 = {21{imm[10]}, imm[10:0]}; zext8 = {24'b0, imm[7:0]}. Bits of imm above the selected width are ignored.
- Output stage: single register (out_valid, out_data, out_slot).
- can_accept = !out_valid || out_ready.
- Arbitration, combinational: scan slots starting at rr_ptr, wrapping modulo NUM_SLOTS; first slot with req_valid wins. req_ready[win] = can_accept; all other req_ready bits 0. No valid requests -> req_ready = 0.
- Transfer on slot i when req_valid[i] && req_ready[i]; the output register loads the extended value and i, and out_valid is set.
- rr_ptr := (win + 1) mod NUM_SLOTS on every transfer; holds otherwise.
- Output drained with no transfer in the same cycle -> out_valid cleared; out_data/out_slot hold their last values.
- A requester must hold req_valid, req_imm and req_mode stable until accepted. The block does not check this.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on any transfer.
  - FULL -> FULL on a drain with a same-cycle transfer (back-to-back).
  - FULL -> EMPTY on a drain with no transfer.
  - FULL holds while out_ready=0.

## Timing
- Reset values: out_valid=0, out_data=0, out_slot=0, rr_ptr=0, err_mode=0. req_ready is 0 during reset cycles.
- Latency: request accepted at edge N -> out_valid/out_data valid after edge N, visible in cycle N+1.
- Throughput: one result per cycle while out_ready=1.
- Backpressure: out_ready=0 with out_valid=1 -> all req_ready=0; output is held stable.
- Simultaneous drain and new accept in one cycle: the new result replaces the old one with no bubble.
- Reset asserted mid-operation: the pending output is discarded. No transfer is reported in a reset cycle, even if req_valid is high.
- No combinational path from req_* to out_*. There is a combinational path out_ready -> req_ready.

## Configuration
- IMM_EXT_MODE_CHECK_EN defined:
  - A mode 11 request is still accepted and arbitrated normally, with out_data = 0.
  - err_mode sets on the accept edge and stays set until reset.
- IMM_EXT_MODE_CHECK_EN undefined:
  - Mode 11 behaves as zext8.
  - The err_mode port is absent.

## Test plan
- Reset, then slot 0 requests imm=11'h080 with sext8 -> one cycle later out_valid=1, out_data=32'hFFFFFF80, out_slot=0.
- Slot 1 requests imm=11'h400 with sext11, and slot 2 requests 11'h7FF with zext8, both presented in the same cycle with out_ready=1 and rr_ptr=0 -> results arrive on consecutive cycles:
  - 32'hFFFFFC00, slot 1.
  - 32'h000000FF, slot 2.
  - rr_ptr ends at 3.
- All 4 slots hold requests continuously with out_ready=1 -> grant order 0,1,2,3,0; one result per cycle; no slot is granted twice before every other slot is granted once.
- Hold out_ready=0 for 3 cycles with a result pending and slot 3 requesting -> req_ready=0 and out_data is stable; on the cycle out_ready rises, slot 3 is accepted and its result appears the next cycle.
- Assert reset while out_valid=1 -> the next cycle shows out_valid=0, out_data=0, rr_ptr=0.
- With IMM_EXT_MODE_CHECK_EN, slot 0 requests with mode 11 -> out_data=0 and err_mode=1, which stays 1 until reset. Without the macro, imm=11'h0A5 with mode 11 -> 32'h000000A5.
